// File: rtl/crc_frame_tx.sv
// -----------------------------------------------------------------------------
// crc_frame_tx
//
// Transmit-side framer for the xSPI 8-bit data path. One payload frame is
// captured into a local buffer, then streamed out byte by byte while the
// framer drives an external crc8 block (clear/enable/data). The finished CRC
// is appended as the trailing byte. The buffered frame is kept until the
// receiver answers: ack releases it, nack or an ack timeout replays it, up to
// MAX_RETRY retransmissions, after which the frame is dropped with a fail
// pulse.
//
// Parameters:
//   MAX_LEN      payload buffer depth in bytes (power of two, >= 2)
//   LEN_W        width of length/index/retry counters (2**LEN_W > MAX_LEN)
//   MAX_RETRY    retransmissions allowed after the first attempt
//   ACK_TIMEOUT  cycles spent in WAIT before silence counts as nack
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_data/in_last  payload byte stream in
//   in_ready                  framer accepts a payload byte
//   tx_valid/tx_data/tx_last  framed byte stream out (tx_last on CRC byte)
//   tx_ready                  downstream accepts the output byte
//   ack, nack                 receiver verdict pulses (only honoured in WAIT)
//   crc_enable/clear/data     drive the external crc8 block
//   crc_in                    crc8 result
//   busy                      framer is not idle
//   done, fail                one-cycle verdict pulses
//   retry_count               retransmissions used for the current frame
// -----------------------------------------------------------------------------
module crc_frame_tx #(
   parameter int MAX_LEN     = 16,
   parameter int LEN_W       = 5,
   parameter int MAX_RETRY   = 3,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             tx_valid,
   output logic [7:0]       tx_data,
   output logic             tx_last,
   input  logic             tx_ready,
   input  logic             ack,
   input  logic             nack,
   output logic             crc_enable,
   output logic             crc_clear,
   output logic [7:0]       crc_data,
   input  logic [7:0]       crc_in,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [LEN_W-1:0] retry_count
);

   localparam int ADDR_W = $clog2(MAX_LEN);
   localparam int TMO_W  = $clog2(ACK_TIMEOUT) + 1;

   localparam logic [LEN_W-1:0] LEN_FULL  = LEN_W'(MAX_LEN - 1);
   localparam logic [LEN_W-1:0] RETRY_MAX = LEN_W'(MAX_RETRY);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PREP,
      ST_SEND,
      ST_CRC,
      ST_WAIT
   } state_t;

   state_t             state_reg;
   logic [LEN_W-1:0]   len_reg;
   logic [LEN_W-1:0]   idx_reg;
   logic [LEN_W-1:0]   retry_reg;
   logic [TMO_W-1:0]   tmo_reg;
   logic               in_ready_reg;
   logic               tx_valid_reg;
   logic [7:0]         tx_data_reg;
   logic               tx_last_reg;
   logic               crc_clear_reg;
   logic               busy_reg;
   logic               done_reg;
   logic               fail_reg;

   // Payload buffer; contents are don't-care after reset so it carries no reset.
   logic [7:0]         buf_mem [MAX_LEN];

   logic               in_fire;
   logic [ADDR_W-1:0]  wr_addr;
   logic [LEN_W-1:0]   idx_inc;
   logic [LEN_W-1:0]   len_m1;
   logic               send_fire;

   // in_ready_reg is only ever high in IDLE/LOAD, so in_fire implies one of them.
   assign in_fire   = in_valid & in_ready_reg;
   assign wr_addr   = (state_reg == ST_IDLE) ? '0 : len_reg[ADDR_W-1:0];
   assign idx_inc   = idx_reg + 1'b1;
   assign len_m1    = len_reg - 1'b1;
   assign send_fire = tx_valid_reg & tx_ready & ~tx_last_reg;

   always_ff @(posedge clk) begin
      if (in_fire) begin
         buf_mem[wr_addr] <= in_data;
      end
   end

   // -------------------------------------------------------------------------
   // Framer FSM. All control outputs are registered here; the next payload
   // byte is read out of buf_mem on the edge that accepts the current one so
   // tx_data is already valid when the next SEND cycle starts.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         len_reg       <= '0;
         idx_reg       <= '0;
         retry_reg     <= '0;
         tmo_reg       <= '0;
         in_ready_reg  <= 1'b0;
         tx_valid_reg  <= 1'b0;
         tx_data_reg   <= '0;
         tx_last_reg   <= 1'b0;
         crc_clear_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         fail_reg      <= 1'b0;
      end else begin
         // Pulse outputs default low every cycle.
         done_reg      <= 1'b0;
         fail_reg      <= 1'b0;
         crc_clear_reg <= 1'b0;

         case (state_reg)
            ST_IDLE: begin
               in_ready_reg <= 1'b1;
               if (in_fire) begin
                  len_reg   <= LEN_W'(1);
                  retry_reg <= '0;
                  busy_reg  <= 1'b1;
                  if (in_last) begin
                     in_ready_reg  <= 1'b0;
                     crc_clear_reg <= 1'b1;
                     state_reg     <= ST_PREP;
                  end else begin
                     state_reg <= ST_LOAD;
                  end
               end
            end

            ST_LOAD: begin
               if (in_fire) begin
                  len_reg <= len_reg + 1'b1;
                  // A byte that fills the buffer closes the frame regardless
                  // of in_last.
                  if (in_last || (len_reg == LEN_FULL)) begin
                     in_ready_reg  <= 1'b0;
                     crc_clear_reg <= 1'b1;
                     state_reg     <= ST_PREP;
                  end
               end
            end

            ST_PREP: begin
               // crc_clear is high during this cycle (set on entry).
               idx_reg      <= '0;
               tx_data_reg  <= buf_mem[0];
               tx_valid_reg <= 1'b1;
               tx_last_reg  <= 1'b0;
               state_reg    <= ST_SEND;
            end

            ST_SEND: begin
               if (tx_ready) begin
                  if (idx_reg == len_m1) begin
                     // CRC byte itself is taken from crc_in (see tx_data mux).
                     tx_last_reg <= 1'b1;
                     state_reg   <= ST_CRC;
                  end else begin
                     idx_reg     <= idx_inc;
                     tx_data_reg <= buf_mem[idx_inc[ADDR_W-1:0]];
                  end
               end
            end

            ST_CRC: begin
               if (tx_ready) begin
                  tx_valid_reg <= 1'b0;
                  tx_last_reg  <= 1'b0;
                  tx_data_reg  <= '0;
                  tmo_reg      <= '0;
                  state_reg    <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               tmo_reg <= tmo_reg + 1'b1;
               // ack has priority over a simultaneous nack.
               if (ack) begin
                  done_reg     <= 1'b1;
                  retry_reg    <= '0;
                  busy_reg     <= 1'b0;
                  in_ready_reg <= 1'b1;
                  state_reg    <= ST_IDLE;
               end else if (nack || (tmo_reg == TMO_LAST)) begin
                  if (retry_reg < RETRY_MAX) begin
                     retry_reg     <= retry_reg + 1'b1;
                     crc_clear_reg <= 1'b1;
                     state_reg     <= ST_PREP;
                  end else begin
                     fail_reg     <= 1'b1;
                     retry_reg    <= '0;
                     busy_reg     <= 1'b0;
                     in_ready_reg <= 1'b1;
                     state_reg    <= ST_IDLE;
                  end
               end
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // crc8 updates on the edge that ends SEND, so crc_in is already final for
   // the whole CRC state and stays put because crc_enable is low there.
   assign tx_data     = (state_reg == ST_CRC) ? crc_in : tx_data_reg;
   assign tx_valid    = tx_valid_reg;
   assign tx_last     = tx_last_reg;
   assign crc_enable  = send_fire;
   assign crc_clear   = crc_clear_reg;
   assign crc_data    = tx_data;
   assign in_ready    = in_ready_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign fail        = fail_reg;
   assign retry_count = retry_reg;

endmodule

// File: tb/tb_crc_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_crc_frame_tx
//
// Directed bench for crc_frame_tx. A small behavioural crc8 (poly 0x07,
// init 0x00) stands in for the real block on the crc_* ports; all expected
// bytes and CRC values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_crc_frame_tx;

   localparam int LEN_W = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic [7:0]       in_data;
   logic             in_last;
   logic             in_ready;
   logic             tx_valid;
   logic [7:0]       tx_data;
   logic             tx_last;
   logic             tx_ready;
   logic             ack;
   logic             nack;
   logic             crc_enable;
   logic             crc_clear;
   logic [7:0]       crc_data;
   logic [7:0]       crc_in;
   logic             busy;
   logic             done;
   logic             fail;
   logic [LEN_W-1:0] retry_count;

   int checks = 0;
   int errors = 0;

   int unsigned cyc = 0;
   int clr_cnt = 0;
   int en_cnt  = 0;
   int in_cnt  = 0;

   logic [8:0]  q  [$];   // {tx_last, tx_data} per output handshake
   int unsigned cq [$];   // cycle stamp per output handshake
   int          rq [$];   // retry_count at each CRC byte handshake

   always #5 clk = ~clk;

   crc_frame_tx #(
      .MAX_LEN(16),
      .LEN_W(LEN_W),
      .MAX_RETRY(3),
      .ACK_TIMEOUT(64)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_last(in_last),
      .in_ready(in_ready),
      .tx_valid(tx_valid),
      .tx_data(tx_data),
      .tx_last(tx_last),
      .tx_ready(tx_ready),
      .ack(ack),
      .nack(nack),
      .crc_enable(crc_enable),
      .crc_clear(crc_clear),
      .crc_data(crc_data),
      .crc_in(crc_in),
      .busy(busy),
      .done(done),
      .fail(fail),
      .retry_count(retry_count)
   );

   // Stand-in for the external crc8 block.
   function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] r;
      r = c ^ d;
      for (int b = 0; b < 8; b++) begin
         r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
      end
      return r;
   endfunction

   logic [7:0] crc_model;
   always @(posedge clk) begin
      if (rst || crc_clear) crc_model <= 8'h00;
      else if (crc_enable)  crc_model <= crc8_step(crc_model, crc_data);
   end
   assign crc_in = crc_model;

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor, sampled half a cycle away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (tx_valid && tx_ready) begin
            q.push_back({tx_last, tx_data});
            cq.push_back(cyc);
            if (tx_last) rq.push_back(int'(retry_count));
            $display("tx  data=%02h last=%0b retry=%0d cyc=%0d", tx_data, tx_last, retry_count, cyc);
         end
         if (crc_clear)            clr_cnt++;
         if (crc_enable)           en_cnt++;
         if (in_valid && in_ready) in_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d, input logic last);
      int k;
      k = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && k < 100) begin
         tick();
         k++;
      end
      if (!in_ready) check("push_ready", {31'd0, in_ready}, 32'd1);
      $display("in  data=%02h last=%0b", d, last);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_tx(input int n, input string tag);
      int k;
      k = 0;
      while (q.size() < n && k < 500) begin
         tick();
         k++;
      end
      check(tag, q.size(), n);
   endtask

   task automatic pulse_verdict(input logic a, input logic n);
      ack  = a;
      nack = n;
      tick();
      ack  = 1'b0;
      nack = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"},  {31'd0, in_ready},   32'd0);
      check({tag, "_tx_valid"},  {31'd0, tx_valid},   32'd0);
      check({tag, "_tx_data"},   {24'd0, tx_data},    32'd0);
      check({tag, "_tx_last"},   {31'd0, tx_last},    32'd0);
      check({tag, "_crc_en"},    {31'd0, crc_enable}, 32'd0);
      check({tag, "_crc_clr"},   {31'd0, crc_clear},  32'd0);
      check({tag, "_crc_data"},  {24'd0, crc_data},   32'd0);
      check({tag, "_busy"},      {31'd0, busy},       32'd0);
      check({tag, "_done"},      {31'd0, done},       32'd0);
      check({tag, "_fail"},      {31'd0, fail},       32'd0);
      check({tag, "_retry"},     {27'd0, retry_count}, 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int clr0, en0, in0, k;
      logic [8:0] e;
      int unsigned fail_cyc;

      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
      tx_ready = 1'b0; ack = 1'b0; nack = 1'b0;

      // ---------------- reset state ----------------
      repeat (3) tick();
      check_all_zero("rst");
      rst = 1'b0;
      tick();
      check("idle_in_ready", {31'd0, in_ready}, 32'd1);

      // ---------------- reference frame 0x31..0x39 ----------------
      tx_ready = 1'b1;
      q.delete(); cq.delete(); rq.delete();
      clr0 = clr_cnt; en0 = en_cnt;
      for (int i = 0; i < 9; i++) push(8'h31 + 8'(i), (i == 8));
      wait_tx(10, "ref_count");
      for (int i = 0; i < 9; i++) begin
         e = {1'b0, 8'h31 + 8'(i)};
         check($sformatf("ref_byte%0d", i), {23'd0, q[i]}, {23'd0, e});
      end
      check("ref_crc", {23'd0, q[9]}, {23'd0, 9'h1F4});
      check("ref_clr_cnt", clr_cnt - clr0, 1);
      check("ref_en_cnt", en_cnt - en0, 9);
      check("ref_wait_busy", {31'd0, busy}, 32'd1);
      check("ref_wait_in_ready", {31'd0, in_ready}, 32'd0);
      pulse_verdict(1'b1, 1'b0);
      check("ref_done", {31'd0, done}, 32'd1);
      check("ref_busy_low", {31'd0, busy}, 32'd0);
      tick();
      check("ref_done_pulse", {31'd0, done}, 32'd0);
      check("ref_in_ready", {31'd0, in_ready}, 32'd1);

      // ---------------- single byte with backpressure ----------------
      tx_ready = 1'b0;
      q.delete(); cq.delete(); rq.delete();
      en0 = en_cnt;
      push(8'h01, 1'b1);
      tick();                                   // PREP -> SEND
      for (int i = 0; i < 3; i++) begin
         check("bp_valid", {31'd0, tx_valid}, 32'd1);
         check("bp_hold_data", {24'd0, tx_data}, 32'h01);
         check("bp_no_en", {31'd0, crc_enable}, 32'd0);
         tick();
      end
      tx_ready = 1'b1;
      #1;
      check("bp_en_on_hs", {31'd0, crc_enable}, 32'd1);
      tick();
      tx_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("bp_crc_data", {24'd0, tx_data}, 32'h07);
         check("bp_crc_last", {31'd0, tx_last}, 32'd1);
         check("bp_crc_no_en", {31'd0, crc_enable}, 32'd0);
         tick();
      end
      tx_ready = 1'b1;
      tick();
      check("bp_en_cnt", en_cnt - en0, 1);
      check("bp_count", q.size(), 2);
      check("bp_byte0", {23'd0, q[0]}, {23'd0, 9'h001});
      check("bp_byte1", {23'd0, q[1]}, {23'd0, 9'h107});
      pulse_verdict(1'b1, 1'b0);
      check("bp_done", {31'd0, done}, 32'd1);

      // ---------------- NACK replay ----------------
      q.delete(); cq.delete(); rq.delete();
      clr0 = clr_cnt;
      tick();
      push(8'hA5, 1'b0);
      push(8'h5A, 1'b1);
      wait_tx(3, "nak_count1");
      check("nak_retry0", {27'd0, retry_count}, 32'd0);
      pulse_verdict(1'b0, 1'b1);
      check("nak_retry1", {27'd0, retry_count}, 32'd1);
      wait_tx(6, "nak_count2");
      pulse_verdict(1'b0, 1'b1);
      check("nak_retry2", {27'd0, retry_count}, 32'd2);
      wait_tx(9, "nak_count3");
      for (int i = 0; i < 3; i++) begin
         check($sformatf("nak_a5_%0d", i), {23'd0, q[3*i]},   {23'd0, 9'h0A5});
         check($sformatf("nak_5a_%0d", i), {23'd0, q[3*i+1]}, {23'd0, 9'h05A});
         check($sformatf("nak_crc_%0d", i), {23'd0, q[3*i+2]}, {23'd0, 9'h1D8});
      end
      pulse_verdict(1'b1, 1'b0);
      check("nak_done", {31'd0, done}, 32'd1);
      check("nak_retry_clr", {27'd0, retry_count}, 32'd0);
      check("nak_clr_cnt", clr_cnt - clr0, 3);

      // ---------------- retry exhaustion by timeout ----------------
      q.delete(); cq.delete(); rq.delete();
      tick();
      push(8'h01, 1'b1);
      k = 0;
      while (!fail && k < 800) begin
         tick();
         k++;
      end
      fail_cyc = cyc;
      check("exh_fail", {31'd0, fail}, 32'd1);
      check("exh_retry_clr", {27'd0, retry_count}, 32'd0);
      check("exh_busy", {31'd0, busy}, 32'd0);
      check("exh_count", q.size(), 8);
      if (q.size() == 8) begin
         for (int i = 0; i < 4; i++) begin
            check($sformatf("exh_data%0d", i), {23'd0, q[2*i]},   {23'd0, 9'h001});
            check($sformatf("exh_crc%0d", i),  {23'd0, q[2*i+1]}, {23'd0, 9'h107});
            check($sformatf("exh_retry%0d", i), rq[i], i);
         end
         check("exh_replay_gap", cq[2] - cq[1], 66);
         check("exh_fail_gap", fail_cyc - cq[7], 65);
      end
      tick();
      check("exh_fail_pulse", {31'd0, fail}, 32'd0);
      check("exh_in_ready", {31'd0, in_ready}, 32'd1);

      // ---------------- overflow: 17 bytes, no in_last ----------------
      q.delete(); cq.delete(); rq.delete();
      in0 = in_cnt;
      for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
      in_valid = 1'b1; in_data = 8'h10; in_last = 1'b1;
      wait_tx(17, "ovf_count");
      check("ovf_in_cnt", in_cnt - in0, 16);
      check("ovf_in_ready", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         e = {1'b0, 8'(i)};
         check($sformatf("ovf_byte%0d", i), {23'd0, q[i]}, {23'd0, e});
      end
      check("ovf_crc_last", {31'd0, q[16][8]}, 32'd1);
      tx_ready = 1'b0;
      pulse_verdict(1'b1, 1'b0);
      check("ovf_done", {31'd0, done}, 32'd1);
      check("ovf_in_cnt_done", in_cnt - in0, 16);
      tick();                                   // 0x10 accepted here
      in_valid = 1'b0; in_last = 1'b0;
      check("ovf_late_accept", in_cnt - in0, 17);
      tick();
      check("ovf_send_valid", {31'd0, tx_valid}, 32'd1);
      check("ovf_send_data", {24'd0, tx_data}, 32'h10);

      // ---------------- reset during SEND, then ack+nack collision ----------------
      rst = 1'b1;
      tick();
      check_all_zero("midrst");
      rst = 1'b0;
      tick();
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      check("midrst_no_done", {31'd0, done}, 32'd0);
      check("midrst_no_fail", {31'd0, fail}, 32'd0);
      pulse_verdict(1'b1, 1'b1);                // ignored outside WAIT
      check("idle_ack_ignored", {31'd0, done}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      tx_ready = 1'b1;
      q.delete(); cq.delete(); rq.delete();
      push(8'h01, 1'b1);
      wait_tx(2, "col_count");
      check("col_crc", {23'd0, q[1]}, {23'd0, 9'h107});
      pulse_verdict(1'b1, 1'b1);
      check("col_done", {31'd0, done}, 32'd1);
      check("col_busy", {31'd0, busy}, 32'd0);
      check("col_retry", {27'd0, retry_count}, 32'd0);
      clr0 = clr_cnt;
      repeat (5) tick();
      check("col_no_replay_clr", clr_cnt - clr0, 0);
      check("col_no_replay_tx", q.size(), 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
